// File: rtl/mblock_access_ctrl.sv
`timescale 1ns/1ps
// mblock_access_ctrl
// Sequences single CPU requests onto the memory block (ROM/RAM/IO/const).
// Each access runs through a setup/strobe/hold sequence, so the write enable
// never overlaps a change on the selector, address or data lines.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_sel/addr/wdata/write request fields, captured on the accept edge
//   resp_valid/rdata/err    one-cycle completion pulse with read data / error
//   mem_selector/address/in registered memory-side request lines
//   mem_is_write            registered level-sensitive write enable
//   mem_out                 memory block read data
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// SETUP  | memory lines stable, counting down the setup time
// STROBE | mem_is_write high, counting down the write pulse
// HOLD   | write enable low again, lines held; also the dead cycle of an
//        | illegal request so its response lands one edge after accept
// RESP   | resp_valid high for this single cycle
module mblock_access_ctrl #(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned WRITE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_sel,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_write,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  mem_selector,
    output logic [15:0] mem_address,
    output logic [31:0] mem_in,
    output logic        mem_is_write,
    input  logic [31:0] mem_out
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] WRITE_LOAD = 8'(WRITE_CYCLES - 1);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        wr_q, wr_nx;
    logic        err_pend, err_pend_nx;
    logic        ready_nx, resp_valid_nx, resp_err_nx, we_nx;
    logic [31:0] resp_rdata_nx, mem_in_nx;
    logic [1:0]  sel_nx;
    logic [15:0] addr_nx;
    logic        illegal;

    assign illegal = (req_sel == 2'b10) || (req_write && (req_sel != 2'b01));

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        wr_nx         = wr_q;
        err_pend_nx   = err_pend;
        ready_nx      = req_ready;
        resp_valid_nx = 1'b0;
        resp_rdata_nx = resp_rdata;
        resp_err_nx   = resp_err;
        sel_nx        = mem_selector;
        addr_nx       = mem_address;
        mem_in_nx     = mem_in;
        we_nx         = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    ready_nx = 1'b0;
                    wr_nx    = req_write;
                    if (illegal) begin
                        // Memory lines stay untouched for a rejected request.
                        err_pend_nx = 1'b1;
                        state_nx    = HOLD;
                    end else begin
                        err_pend_nx = 1'b0;
                        sel_nx      = req_sel;
                        addr_nx     = req_addr;
                        mem_in_nx   = req_wdata;
                        cnt_nx      = SETUP_LOAD;
                        state_nx    = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    if (wr_q) begin
                        cnt_nx   = WRITE_LOAD;
                        we_nx    = 1'b1;
                        state_nx = STROBE;
                    end else begin
                        resp_rdata_nx = mem_out;
                        resp_err_nx   = 1'b0;
                        resp_valid_nx = 1'b1;
                        state_nx      = RESP;
                    end
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            STROBE: begin
                if (cnt == 8'd0) begin
                    state_nx = HOLD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                    we_nx  = 1'b1;
                end
            end
            HOLD: begin
                // Reached by completed writes and by rejected requests only.
                resp_rdata_nx = 32'd0;
                resp_err_nx   = err_pend;
                resp_valid_nx = 1'b1;
                state_nx      = RESP;
            end
            RESP: begin
                ready_nx = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                ready_nx = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            wr_q         <= 1'b0;
            err_pend     <= 1'b0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            resp_err     <= 1'b0;
            mem_selector <= 2'b00;
            mem_address  <= 16'd0;
            mem_in       <= 32'd0;
            mem_is_write <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            wr_q         <= wr_nx;
            err_pend     <= err_pend_nx;
            req_ready    <= ready_nx;
            resp_valid   <= resp_valid_nx;
            resp_rdata   <= resp_rdata_nx;
            resp_err     <= resp_err_nx;
            mem_selector <= sel_nx;
            mem_address  <= addr_nx;
            mem_in       <= mem_in_nx;
            mem_is_write <= we_nx;
        end
    end

endmodule

// File: doc/mblock_access_ctrl.md
Name: mblock_access_ctrl

Overview:
Sequencer directly upstream of the memory block (ROM/RAM/IO/const selector, 16-bit address, 32-bit data, level-sensitive write enable). Accepts one request at a time from the CPU core via a valid/ready handshake. Drives the memory-side selector, address, data and write enable from registers, with a setup/strobe/hold sequence so the write enable never overlaps address or data transitions. Rejects illegal accesses and returns read data with a one-cycle response pulse.

Parameters:
SETUP_CYCLES, 1, cycles address/selector/data are stable before capture or strobe (1..255)
WRITE_CYCLES, 1, cycles mem_is_write is held high (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept (high only in IDLE)
req_sel  input  2  00 ROM, 01 RAM, 10 IO (reserved), 11 const
req_addr  input  16  word address
req_wdata  input  32  write data; also operand for const reads
req_write  input  1  1 = write, 0 = read
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  read data, valid with resp_valid
resp_err  output  1  illegal access flag, valid with resp_valid
mem_selector  output  2  to memory block selector
mem_address  output  16  to memory block address
mem_in  output  32  to memory block data in
mem_is_write  output  1  to memory block write enable
mem_out  input  32  from memory block data out

Behaviour:
- One clock. Reset is asynchronous and active-high. All outputs are registered.
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_selector=00; mem_address=0; mem_in=0; mem_is_write=0. Reset asserted mid-operation forces mem_is_write low immediately, without waiting for a clock, and abandons the request with no response.
- States: IDLE, SETUP, STROBE, HOLD, RESP. An 8-bit down-counter times SETUP and STROBE.
- IDLE:
  - On req_valid & req_ready (accept edge E0), latch sel/addr/wdata/write into mem_selector/mem_address/mem_in.
  - Legality:
    - sel=10, read or write: illegal.
    - write with sel≠01: illegal.
  - Illegal request: go to RESP with err=1, rdata=0. Memory outputs are not updated and mem_is_write is never asserted.
  - Legal request: go to SETUP with counter=SETUP_CYCLES-1.
- SETUP:
  - Decrement the counter.
  - At counter 0, a read captures mem_out into resp_rdata and goes to RESP.
  - At counter 0, a write goes to STROBE with counter=WRITE_CYCLES-1.
- STROBE: mem_is_write=1. At counter 0, go to HOLD.
- HOLD: mem_is_write=0 for one cycle, with address/selector/data unchanged. Then go to RESP.
- RESP: resp_valid=1 for exactly one cycle. resp_rdata/resp_err hold until the next RESP. Then go to IDLE.
- Memory-side outputs are held at their last values in every state other than the accept edge. mem_is_write=1 only in STROBE.
- Latency, with resp_valid visible after edge En counted from E0:
  - Read: E(SETUP_CYCLES).
  - Write: E(SETUP_CYCLES+WRITE_CYCLES+1).
  - Illegal: E1.
  - Defaults: read E1, write E3.
- req_ready=0 from E0 until the cycle after RESP, so there is no back-to-back acceptance. Request inputs are ignored while busy.
- Const reads (sel=11): resp_rdata = mem_out, which is req_wdata passed through the memory block.
- Write responses return resp_rdata=0, err=0.

Test Plan:
1. RAM write sel=01, addr=0x0010, data=0xDEADBEEF -> mem_is_write high exactly 1 cycle; address/data stable from E0 through HOLD; resp_valid at E3 with err=0. Then read the same address -> rdata=0xDEADBEEF at E1.
2. Write with sel=00 (ROM) and again with sel=11 -> resp_err=1 at E1; mem_is_write never asserted; mem_address unchanged from its previous value.
3. Read with sel=10, addr=0x0004 -> resp_err=1, resp_rdata=0 at E1.
4. Const read sel=11, wdata=0x12345678 -> resp_rdata=0x12345678, err=0. Then ROM read addr 0 -> rdata equals the ROM boot word 0.
5. Assert reset during STROBE with SETUP_CYCLES=2, WRITE_CYCLES=3 -> mem_is_write falls before the next clock edge; no resp_valid; req_ready=1 after release. Then a full write completes with resp_valid at E6.
6. Hold req_valid high and change req_addr every cycle while busy -> only the E0 request is accepted; memory outputs do not change; second accept occurs the cycle after resp_valid.
